// File: rtl/pc_update_ras.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pc_update_ras : Y86-64 SEQ PC update with stall, status machine  |
// |                 and a return-address stack checking ret targets  |
// | Revision      : 1.0                                              |
// +------------------------------------------------------------------+
module pc_update_ras #(
  parameter int                ADDR_W    = 64,
  parameter int                RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic [3:0]                 icode,
  input  logic                       cnd,
  input  logic                       imem_error,
  input  logic [ADDR_W-1:0]          valC,
  input  logic [ADDR_W-1:0]          valM,
  input  logic [ADDR_W-1:0]          valP,
  output logic [ADDR_W-1:0]          pc,
  output logic [1:0]                 stat,
  output logic                       ras_hit,
  output logic                       ras_miss,
  output logic [$clog2(RAS_DEPTH):0] ras_count
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(RAS_DEPTH);

  localparam logic [3:0] c_IC_HALT = 4'h0;
  localparam logic [3:0] c_IC_JXX  = 4'h7;
  localparam logic [3:0] c_IC_CALL = 4'h8;
  localparam logic [3:0] c_IC_RET  = 4'h9;
  localparam logic [3:0] c_IC_MAX  = 4'hB;

  typedef enum logic [1:0] {
    S_AOK = 2'b00,
    S_HLT = 2'b01,
    S_INS = 2'b10,
    S_ADR = 2'b11
  } stat_t;

  stat_t             r_stat;
  logic [ADDR_W-1:0] r_pc;
  logic [PTR_W-1:0]  r_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_hit;
  logic              r_miss;
  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];

  logic              w_update;
  logic              w_push;
  logic [PTR_W-1:0]  w_ptr_dec;
  logic              w_nonempty;
  logic              w_top_match;

  always_comb begin
    w_update    = (r_stat == S_AOK) && !stall;
    w_push      = w_update && !imem_error && (icode == c_IC_CALL);
    w_ptr_dec   = r_ptr - 1'b1;
    w_nonempty  = (r_cnt != '0);
    // Only look at stack contents once an entry is known to be written.
    w_top_match = w_nonempty && (r_ras[w_ptr_dec] == valM);
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_ras[r_ptr] <= valP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat <= S_AOK;
      r_pc   <= RESET_PC;
      r_ptr  <= '0;
      r_cnt  <= '0;
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
    end else begin
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
      if (w_update) begin
        if (imem_error) begin
          r_stat <= S_ADR;
        end else if (icode > c_IC_MAX) begin
          r_stat <= S_INS;
        end else begin
          case (icode)
            c_IC_HALT: begin
              r_stat <= S_HLT;
              r_pc   <= valP;
            end
            c_IC_JXX: r_pc <= cnd ? valC : valP;
            c_IC_CALL: begin
              r_pc  <= valC;
              r_ptr <= r_ptr + 1'b1;
              // Full stack overwrites its oldest entry; count saturates.
              if (r_cnt != c_CNT_FULL) begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
            c_IC_RET: begin
              r_pc <= valM;
              if (w_nonempty) begin
                r_ptr  <= w_ptr_dec;
                r_cnt  <= r_cnt - 1'b1;
                r_hit  <= w_top_match;
                r_miss <= !w_top_match;
              end else begin
                r_miss <= 1'b1;
              end
            end
            default: r_pc <= valP;
          endcase
        end
      end
    end
  end

  assign pc        = r_pc;
  assign stat      = r_stat;
  assign ras_hit   = r_hit;
  assign ras_miss  = r_miss;
  assign ras_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_update_ras.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pc_update_ras : scoreboard bench for pc_update_ras            |
// | Revision         : 1.0                                           |
// +------------------------------------------------------------------+
module tb_pc_update_ras;

  localparam int          ADDR_W    = 64;
  localparam int          RAS_DEPTH = 8;
  localparam logic [63:0] RESET_PC  = 64'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [3:0]  icode = 4'h1;
  logic        cnd = 1'b0;
  logic        imem_error = 1'b0;
  logic [63:0] valC = '0;
  logic [63:0] valM = '0;
  logic [63:0] valP = '0;
  logic [63:0] pc;
  logic [1:0]  stat;
  logic        ras_hit;
  logic        ras_miss;
  logic [3:0]  ras_count;

  pc_update_ras #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .icode     (icode),
    .cnd       (cnd),
    .imem_error(imem_error),
    .valC      (valC),
    .valM      (valM),
    .valP      (valP),
    .pc        (pc),
    .stat      (stat),
    .ras_hit   (ras_hit),
    .ras_miss  (ras_miss),
    .ras_count (ras_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [1:0]  stat;
    logic        hit;
    logic        miss;
    int          cnt;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;

  // Reference model: architectural state plus a bounded queue as the stack.
  logic [63:0] m_pc   = RESET_PC;
  logic [1:0]  m_stat = 2'b00;
  logic [63:0] m_ras[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every edge produces one observable state; compare against the head.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pc",        pc,                e.pc);
      chk("stat",      {62'd0, stat},     {62'd0, e.stat});
      chk("ras_hit",   {63'd0, ras_hit},  {63'd0, e.hit});
      chk("ras_miss",  {63'd0, ras_miss}, {63'd0, e.miss});
      chk("ras_count", {60'd0, ras_count}, 64'(e.cnt));
    end
  end

  task automatic drive(input logic r, input logic s, input logic [3:0] ic, input logic c,
                       input logic ie, input logic [63:0] vc, input logic [63:0] vm,
                       input logic [63:0] vp);
    exp_t        e;
    logic [63:0] top;
    @(negedge clk);
    rst = r; stall = s; icode = ic; cnd = c; imem_error = ie;
    valC = vc; valM = vm; valP = vp;
    e.hit  = 1'b0;
    e.miss = 1'b0;
    if (r) begin
      m_pc   = RESET_PC;
      m_stat = 2'b00;
      m_ras.delete();
    end else if (m_stat == 2'b00 && !s) begin
      if (ie)                m_stat = 2'b11;
      else if (ic > 4'hB)    m_stat = 2'b10;
      else if (ic == 4'h0) begin m_stat = 2'b01; m_pc = vp; end
      else if (ic == 4'h7)   m_pc = c ? vc : vp;
      else if (ic == 4'h8) begin
        m_pc = vc;
        m_ras.push_back(vp);
        if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
      end else if (ic == 4'h9) begin
        m_pc = vm;
        if (m_ras.size() == 0) e.miss = 1'b1;
        else begin
          top = m_ras.pop_back();
          if (top == vm) e.hit = 1'b1;
          else           e.miss = 1'b1;
        end
      end else m_pc = vp;
    end
    e.pc   = m_pc;
    e.stat = m_stat;
    e.cnt  = m_ras.size();
    sb.push_back(e);
  endtask

  task automatic op(input logic [3:0] ic, input logic [63:0] vc, input logic [63:0] vm,
                    input logic [63:0] vp);
    drive(1'b0, 1'b0, ic, 1'b0, 1'b0, vc, vm, vp);
  endtask

  initial begin
    // Reset and sequential flow
    drive(1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 0, 0, 0);
    op(4'h1, 0, 0, 64'h0A);
    op(4'h3, 0, 0, 64'h14);
    // Conditional jump, taken / not taken / stalled
    drive(1'b0, 1'b0, 4'h7, 1'b1, 1'b0, 64'h40, 0, 64'h20);
    drive(1'b0, 1'b0, 4'h7, 1'b0, 1'b0, 64'h40, 0, 64'h20);
    drive(1'b0, 1'b1, 4'h7, 1'b1, 1'b0, 64'h40, 0, 64'h20);
    // Stalled ret/call must not touch the stack
    drive(1'b0, 1'b1, 4'h9, 1'b0, 1'b0, 0, 64'h77, 0);
    // Matched call/ret, mismatched ret, empty ret
    op(4'h8, 64'h100, 0, 64'h29);
    op(4'h9, 0, 64'h29, 0);
    op(4'h8, 64'h200, 0, 64'h30);
    op(4'h9, 0, 64'h38, 0);
    op(4'h9, 0, 64'h50, 0);
    // Overflow: 10 calls, 8 matching rets, then empty
    for (int i = 0; i < 10; i++) op(4'h8, 64'h300, 0, 64'h10 + 64'(i));
    for (int i = 0; i < 8; i++)  op(4'h9, 0, 64'h19 - 64'(i), 0);
    op(4'h9, 0, 64'h11, 0);
    // Status machine
    op(4'h0, 0, 0, 64'h60);
    drive(1'b0, 1'b0, 4'h7, 1'b1, 1'b0, 64'h99, 0, 64'h98);
    op(4'h9, 0, 64'h5, 0);
    drive(1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 0, 0, 0);
    op(4'hC, 0, 0, 64'h70);
    op(4'h1, 0, 0, 64'h74);
    drive(1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 0, 0, 0);
    op(4'h1, 0, 0, 64'h80);
    drive(1'b0, 1'b0, 4'h8, 1'b0, 1'b1, 64'h90, 0, 64'h88);
    op(4'h1, 0, 0, 64'h84);
    op(4'h0, 0, 0, 64'h90);
    drive(1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 0, 0, 0);
    // Randomised traffic, biased toward calls/rets and matching targets
    for (int n = 0; n < 3000; n++) begin
      logic [3:0]  ic;
      logic [63:0] vm;
      int          sel;
      sel = $urandom_range(0, 99);
      if (sel < 30)      ic = 4'h8;
      else if (sel < 60) ic = 4'h9;
      else if (sel < 75) ic = 4'h7;
      else if (sel < 77) ic = 4'h0;
      else if (sel < 79) ic = 4'(4'hC + $urandom_range(0, 3));
      else               ic = 4'($urandom_range(1, 11));
      vm = {$urandom, $urandom};
      if (m_ras.size() != 0 && $urandom_range(0, 2) != 0) vm = m_ras[$];
      drive(($urandom_range(0, 199) == 0) || (m_stat != 2'b00 && $urandom_range(0, 3) == 0),
            $urandom_range(0, 4) == 0, ic, 1'($urandom), $urandom_range(0, 99) == 0,
            {$urandom, $urandom}, vm, {$urandom, $urandom});
    end
    @(negedge clk);
    for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_update_ras.md
Name: pc_update_ras

Overview:
- Parametrised successor to the sequential Y86-64 PC update stage.
- Registers the next PC from icode/cnd/valC/valM/valP, as the single-cycle PC update does.
- Adds stall hold, a processor status machine (AOK/HLT/INS/ADR), and a return-address stack (RAS) that checks every ret target against valM.
- Sits after write-back in the SEQ datapath and feeds the PC to fetch.

Parameters:
- ADDR_W, 64, PC/address width in bits.
- RAS_DEPTH, 8, RAS entries (power of two, >=2).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  when 1, hold all state this cycle.
- icode  in  4  instruction code of the retiring instruction.
- cnd  in  1  jump condition from execute.
- imem_error  in  1  fetch address error for this instruction.
- valC  in  ADDR_W  constant/destination word.
- valM  in  ADDR_W  memory read value (return address for ret).
- valP  in  ADDR_W  fall-through PC.
- pc  out  ADDR_W  current PC.
- stat  out  2  00 AOK, 01 HLT, 10 INS, 11 ADR.
- ras_hit  out  1  one-cycle pulse: ret target matched RAS top.
- ras_miss  out  1  one-cycle pulse: ret target mismatched, or RAS empty.
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.

Behaviour:
- Reset (rst=1 at an edge; priority over everything, including stall):
  - pc=RESET_PC, stat=00, ras_count=0, RAS pointer=0.
  - ras_hit=0, ras_miss=0.
  - RAS contents need not be cleared.
- State machine on stat:
  - AOK is the only state that updates the PC.
  - HLT, INS and ADR are terminal until rst. In them, pc, RAS and ras_count are frozen and pulses stay 0.
- Update at each edge with stat=AOK and stall=0, evaluated in this priority order:
  1. imem_error=1 -> stat=ADR, pc unchanged, RAS unchanged.
  2. icode>4'hB -> stat=INS, pc unchanged.
  3. icode=4'h0 (halt) -> stat=HLT, pc=valP.
  4. icode=4'h7 (jXX) -> pc = cnd ? valC : valP.
  5. icode=4'h8 (call) -> pc=valC. Push valP onto the RAS.
  6. icode=4'h9 (ret) -> pc=valM (always architecturally correct). Pop the RAS and compare the popped entry with valM:
     - equal -> ras_hit=1;
     - unequal -> ras_miss=1;
     - RAS empty -> ras_miss=1, no pop, ras_count stays 0.
  7. All other icodes -> pc=valP.
- stall=1 in AOK: all state held, no push/pop, ras_hit=ras_miss=0.
- Latency: pc reflects the instruction presented one edge earlier, i.e. one cycle.
- ras_hit/ras_miss are registered, high for exactly the one cycle after the ret edge, and are never both 1.
- RAS organisation:
  - Circular buffer indexed by a $clog2(RAS_DEPTH)-bit top pointer that wraps modulo RAS_DEPTH.
  - Push writes entry[ptr] then ptr+1.
  - Pop reads entry[ptr-1] then ptr-1.
- RAS full (ras_count=RAS_DEPTH) and a push:
  - Oldest entry is overwritten; ptr still advances; ras_count saturates at RAS_DEPTH.
  - A later pop past the overwritten depth hits the empty case only when ras_count reaches 0.
- Width rules:
  - All PC arithmetic is pure selection; no adders on the PC path.
  - ras_count must be wide enough to hold RAS_DEPTH.
- Unknown-free: no output may depend on RAS contents that were never written. Gate the comparison with ras_count!=0.

Test Plan:
- Reset/sequential flow:
  - rst=1 then release; icode=1, valP=0x0A -> pc=0x0A, stat=00.
  - icode=3, valP=0x14 -> pc=0x14.
- Conditional jump:
  - icode=7, valC=0x40, valP=0x20, cnd=1 -> pc=0x40.
  - Same with cnd=0 -> pc=0x20.
  - Same with stall=1 -> pc unchanged.
- Call/ret matched:
  - call valC=0x100, valP=0x29 -> pc=0x100, ras_count=1.
  - ret valM=0x29 -> pc=0x29, ras_hit=1 for one cycle, ras_count=0.
- Ret mismatch and empty:
  - call valP=0x30, then ret valM=0x38 -> pc=0x38, ras_miss=1.
  - A second ret valM=0x50 on an empty RAS -> pc=0x50, ras_miss=1, ras_count=0.
- RAS overflow (RAS_DEPTH=8):
  - 10 calls with valP=0x10..0x19 -> ras_count=8.
  - 8 rets with valM=0x19 down to 0x12 -> all ras_hit.
  - 9th ret valM=0x11 -> ras_miss (empty).
- Status machine:
  - icode=0, valP=0x60 -> stat=01, pc=0x60; later icode=7 cnd=1 is ignored.
  - rst, then icode=0xC -> stat=10.
  - rst, then imem_error=1 -> stat=11, pc unchanged.
  - rst mid-HLT -> pc=RESET_PC, stat=00.
